conv_window_gen: RTL and testbench

Streaming sliding-window generator that sits directly upstream of each convolve layer. It accepts one feature-map pixel per handshake in row-major order and buffers the last KERNEL_SIZE-1 rows in line buffers. For every valid stride-1 kernel position it emits a full KERNEL_SIZE×KERNEL_SIZE window, so the convolve layer no longer computes addresses or kernel offsets itself.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/line_buffer.sv | 47 ++++
 rtl/conv_window_gen.sv | 182 ++++++++++++++++++
 tb/tb_conv_window_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default pixel width, layer image sizes,
// pixel type and the window-generator control states.
package cnn_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int L1_IN_WIDTH     = 28;
  localparam int L1_IN_HEIGHT    = 28;

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of delay: the value read out is the one written DEPTH enabled
// cycles earlier, using a single shared read/write index.
module line_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = L1_IN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Contents are refilled by the first rows of every frame, so no reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

  assign dout_o = mem_q[ptr_q];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator: row-major pixels in, one packed
// stride-1 window out per valid kernel position, with a single output register.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH   = L1_IN_WIDTH,
  parameter int IMG_HEIGHT  = L1_IN_HEIGHT,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [DATA_WIDTH-1:0]                          in_data,
  output logic                                           win_valid,
  input  logic                                           win_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]  win_data,
  output logic [$clog2(IMG_WIDTH)-1:0]                   win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]                   win_col,
  output logic                                           done
);

  localparam int KM1 = KERNEL_SIZE - 1;
  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int WW  = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_K    = CW'(KM1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(KM1);

  win_state_t state_q, state_d;

  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  taken_q, taken_d;
  logic                  win_valid_q, win_valid_d;
  logic [WW-1:0]         win_data_q, win_data_d;
  logic [CW-1:0]         win_row_q, win_row_d;
  logic [CW-1:0]         win_col_q, win_col_d;
  logic [DATA_WIDTH-1:0] sr_q [KERNEL_SIZE][KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] sr_d [KERNEL_SIZE][KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] chain [KERNEL_SIZE];
  logic [WW-1:0]         win_pack;

  logic accept;
  logic start_ok;
  logic emit;

  assign accept   = in_valid && in_ready;
  assign start_ok = (state_q == IDLE) && start;
  assign emit     = accept && (row_q >= ROW_K) && (col_q >= COL_K);

  // chain[0] is the live pixel; chain[i+1] is the same column i+1 rows earlier.
  assign chain[0] = in_data;

  for (genvar i = 0; i < KM1; i++) begin : g_lb
    line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH)
    ) u_lb (
      .clk    (clk),
      .reset  (reset),
      .en_i   (accept),
      .din_i  (chain[i]),
      .dout_o (chain[i+1])
    );
  end

  always_comb begin
    sr_d = sr_q;
    if (accept) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KM1; c++) begin
          sr_d[r][c] = sr_q[r][c+1];
        end
        sr_d[r][KM1] = chain[KM1-r];
      end
    end
  end

  always_comb begin
    win_pack = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        win_pack[(r*KERNEL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] = sr_d[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  // Pixel counters and the output register.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    taken_d     = taken_q;
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (start_ok) begin
      row_d   = '0;
      col_d   = '0;
      taken_d = 1'b0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          taken_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (emit) begin
      win_valid_d = 1'b1;
      win_data_d  = win_pack;
      win_row_d   = CW'(row_q - ROW_K);
      win_col_d   = col_q - COL_K;
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q       <= '0;
      col_q       <= '0;
      taken_q     <= 1'b0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      taken_q     <= taken_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The last window is the only one that can drain once every pixel is in.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACTIVE;
      ACTIVE:  if (win_valid_q && win_ready && taken_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ACTIVE) && !taken_q && (!win_valid_q || win_ready);
    done     = (state_q == DONE);
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a frame-image model predicts every
// window, a monitor compares each presented window and the done pulse.
module tb_conv_window_gen;
  import cnn_pkg::*;

  localparam int DW = 16;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int K  = 3;
  localparam int NW = (W - K + 1) * (H - K + 1);
  localparam int NP = W * H;
  localparam int XW = K * K * DW;
  localparam int CW = $clog2(W);
  localparam int LIMIT = 20000;

  typedef struct {
    logic [XW-1:0] data;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    int            cyc;
    bit            seen;
  } win_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  pixel_t        in_data = '0;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic [XW-1:0] win_data;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          done;

  conv_window_gen #(
    .DATA_WIDTH  (DW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .KERNEL_SIZE (K)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_row   (win_row),
    .win_col   (win_col),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] img [H][W];
  win_t          sb[$];
  bit            m_active = 0;
  int            m_pix = 0;
  int            win_cnt = 0;
  int            exp_done_cyc = -1;
  int            done_cnt = 0;
  int            fr_wins = 0;
  logic [XW-1:0] f_first_data;
  logic [CW-1:0] f_first_row, f_first_col;
  logic [XW-1:0] f_last_data;
  logic [CW-1:0] f_last_row, f_last_col;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        m_active = 0;
        m_pix = 0;
        win_cnt = 0;
        exp_done_cyc = -1;
        continue;
      end
      check("done_pulse", done, (cyc == exp_done_cyc));
      if (done) begin
        done_cnt++;
        fr_wins = win_cnt;
      end
      if (!m_active) check("in_ready_idle", in_ready, 0);
      if (start && !m_active) begin
        m_active = 1;
        m_pix = 0;
        win_cnt = 0;
      end
      if (cyc == exp_done_cyc) m_active = 0;
      if (win_valid && !win_ready) check("in_ready_backpressure", in_ready, 0);
      if (win_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_window", 1, 0);
        end else begin
          check("win_data", win_data, sb[0].data);
          check("win_row", win_row, sb[0].row);
          check("win_col", win_col, sb[0].col);
          if (!sb[0].seen) check("win_latency", cyc, sb[0].cyc);
          sb[0].seen = 1;
          if (win_ready) begin
            if (win_cnt == 0) begin
              f_first_data = win_data;
              f_first_row  = win_row;
              f_first_col  = win_col;
            end
            f_last_data = win_data;
            f_last_row  = win_row;
            f_last_col  = win_col;
            win_cnt++;
            void'(sb.pop_front());
            if (m_pix == NP && sb.size() == 0) exp_done_cyc = cyc + 1;
          end
        end
      end
      if (in_valid && in_ready) begin
        if (m_pix >= NP) begin
          check("accept_after_last_pixel", m_pix, NP - 1);
        end else begin
          int r;
          int c;
          r = m_pix / W;
          c = m_pix % W;
          img[r][c] = in_data;
          if (r >= K - 1 && c >= K - 1) begin
            win_t w;
            w.data = '0;
            for (int i = 0; i < K; i++)
              for (int j = 0; j < K; j++)
                w.data[(i*K+j)*DW +: DW] = img[r-K+1+i][c-K+1+j];
            w.row  = CW'(r - K + 1);
            w.col  = CW'(c - K + 1);
            w.cyc  = cyc + 1;
            w.seen = 0;
            sb.push_back(w);
          end
          m_pix++;
        end
      end
    end
  end

  // mode 0: ramp data, always valid/ready; mode 1: random data and handshakes
  task automatic run_frame(input int mode, input int abort_at);
    int  pix = 0;
    int  guard = 0;
    int  stall = 0;
    int  d0;
    bit  took;
    bit  stalled = 0;
    bit  mid = 0;
    d0 = done_cnt;
    in_valid = 1'b1;
    in_data  = (mode == 0) ? '0 : pixel_t'($urandom);
    win_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (done_cnt == d0 && guard < LIMIT) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (took) pix++;
      if (abort_at > 0 && pix >= abort_at) begin
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abort_win_valid", win_valid, 0);
        check("abort_done", done, 0);
        @(posedge clk); #1 reset = 1'b0;
        return;
      end
      if (mode == 0) begin
        start     = 1'b0;
        in_valid  = (pix < NP);
        in_data   = pixel_t'(pix);
        win_ready = 1'b1;
      end else begin
        start    = (pix >= 400 && !mid);
        if (start) mid = 1;
        in_valid = ($urandom_range(0, 3) != 0);
        if (took || pix == 0) in_data = pixel_t'($urandom);
        if (stall > 0) begin
          win_ready = 1'b0;
          stall--;
        end else if (!stalled && pix >= 300 && win_valid) begin
          stalled = 1;
          stall = 4;
          win_ready = 1'b0;
        end else begin
          win_ready = ($urandom_range(0, 4) != 0);
        end
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    win_ready = 1'b1;
    check("frame_within_budget", (guard < LIMIT), 1);
  endtask

  task automatic ramp_checks(input string tag);
    int d0;
    d0 = done_cnt;
    check({tag, "_windows"}, fr_wins, NW);
    check({tag, "_first_row"}, f_first_row, 0);
    check({tag, "_first_col"}, f_first_col, 0);
    check({tag, "_first_e00"}, f_first_data[0 +: DW], 0);
    check({tag, "_first_e11"}, f_first_data[(1*K+1)*DW +: DW], 29);
    check({tag, "_first_e22"}, f_first_data[(2*K+2)*DW +: DW], 58);
    check({tag, "_last_row"}, f_last_row, 25);
    check({tag, "_last_col"}, f_last_col, 25);
    check({tag, "_last_e22"}, f_last_data[(2*K+2)*DW +: DW], 783);
    repeat (5) @(posedge clk);
    #1 check({tag, "_single_done"}, done_cnt, d0);
  endtask

  initial begin : driver
    int d0;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_data", win_data, 0);
    check("rst_win_row", win_row, 0);
    check("rst_win_col", win_col, 0);
    check("rst_done", done, 0);

    run_frame(0, 0);
    ramp_checks("ramp1");

    run_frame(1, 0);
    check("random_windows", fr_wins, NW);

    d0 = done_cnt;
    run_frame(0, 100);
    repeat (20) @(posedge clk);
    #1 check("abort_no_done", done_cnt, d0);

    // start together with reset must leave the block idle
    start = 1'b1;
    reset = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("start_under_reset_idle", in_ready, 0);

    run_frame(0, 0);
    ramp_checks("ramp2");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
